// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared FSM/owner types and memory timing for the port arbiter.
package mem_port_arbiter_pkg;
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;
   typedef enum logic {OWN_I, OWN_D} owner_t;
   localparam int MEM_RD_LATENCY = 1;
endpackage

// File: rtl/mem_port_arbiter_rr_picker2.sv
// rr_picker2: two-way round-robin winner select; a conflict goes to the side not granted last.
module rr_picker2
   import mem_port_arbiter_pkg::*;
(
   input  logic   i_elig_i,
   input  logic   i_elig_d,
   input  owner_t i_last,
   output owner_t o_winner
);
   assign o_winner = (i_elig_d && (!i_elig_i || i_last == OWN_I)) ? OWN_D : OWN_I;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-cycle-latency memory port between a fetch and a data requester.
// Each access is IDLE/RESP -> ISSUE -> RESP; misaligned fetches bypass ISSUE and ack with an error.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [63:0] i_addr,
   output logic        i_ack,
   output logic        i_err,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [63:0] d_addr,
   input  logic [63:0] d_wdata,
   input  logic [7:0]  d_be,
   output logic        d_ack,
   output logic [63:0] d_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic [7:0]  mem_be,
   input  logic [63:0] mem_rdata
);
   state_t      r_state, w_state_nxt;
   owner_t      r_owner, r_last, w_winner;
   logic [63:0] r_addr, r_wdata;
   logic [7:0]  r_be;
   logic        r_we, r_err;
   logic        w_issue, w_resp, w_i_elig, w_d_elig, w_load, w_mis, w_win_d;

   assign w_issue  = r_state == S_ISSUE;
   assign w_resp   = r_state == S_RESP;
   // the requester being acked this cycle cannot win again immediately
   assign w_i_elig = i_req && !(w_resp && r_owner == OWN_I);
   assign w_d_elig = d_req && !(w_resp && r_owner == OWN_D);
   assign w_win_d  = w_winner == OWN_D;

   rr_picker2 u_pick (
      .i_elig_i (w_i_elig),
      .i_elig_d (w_d_elig),
      .i_last   (r_last),
      .o_winner (w_winner)
   );

   always_comb begin
      w_load      = !w_issue && (w_i_elig || w_d_elig);
      w_mis       = !w_win_d && i_addr[1:0] != 2'b00;
      w_state_nxt = w_issue ? S_RESP : !w_load ? S_IDLE : w_mis ? S_RESP : S_ISSUE;
      mem_en      = reset && w_issue;
      mem_we      = mem_en && r_owner == OWN_D && r_we;
      i_ack       = reset && w_resp && r_owner == OWN_I;
      d_ack       = reset && w_resp && r_owner == OWN_D;
      i_err       = i_ack && r_err;
      i_rdata     = (i_ack && !r_err) ? (r_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0]) : '0;
      d_rdata     = d_ack ? mem_rdata : '0;
      mem_addr    = reset ? r_addr : '0;
      mem_wdata   = reset ? r_wdata : '0;
      mem_be      = reset ? r_be : '0;
   end

   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_owner <= OWN_I;
         r_last  <= OWN_I;
         r_addr  <= '0;
         r_wdata <= '0;
         r_be    <= '0;
         r_we    <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         if (w_resp) r_last <= r_owner;
         if (w_load) begin
            r_owner <= w_winner;
            r_addr  <= w_win_d ? d_addr : i_addr;
            r_we    <= w_win_d && d_we;
            r_wdata <= w_win_d ? d_wdata : '0;
            r_be    <= (w_win_d && d_we) ? d_be : 8'hFF;
            r_err   <= w_mis;
         end
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven single accesses with a scoreboard, plus round-robin and reset-abort sequences.
module tb_mem_port_arbiter;
   logic        clk, reset;
   logic        i_req, i_ack, i_err;
   logic [63:0] i_addr;
   logic [31:0] i_rdata;
   logic        d_req, d_we, d_ack;
   logic [63:0] d_addr, d_wdata, d_rdata;
   logic [7:0]  d_be;
   logic        mem_en, mem_we;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   logic [7:0]  mem_be;
   logic        pre_en;
   logic [7:0]  pre_idx;
   logic [63:0] pre_val;
   logic [63:0] mem [0:255];
   int          n_chk = 0;
   int          n_err = 0;

   typedef struct {
      logic        is_d;
      logic        we;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [7:0]  be;
      logic        pre;
      logic [63:0] pre_val;
      logic [63:0] exp_data;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   typedef struct {
      logic        is_d;
      logic [63:0] data;
      logic        err;
      int          lat;
   } exp_t;

   vec_t vecs [12];
   exp_t sb [$];

   mem_port_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_ack     (i_ack),
      .i_err     (i_err),
      .i_rdata   (i_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_be      (d_be),
      .d_ack     (d_ack),
      .d_rdata   (d_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory model: samples on the edge ending a mem_en cycle, answers in the next cycle
   always @(posedge clk) begin
      if (pre_en) mem[pre_idx] <= pre_val;
      if (mem_en) begin
         if (mem_we) begin
            for (int b = 0; b < 8; b++)
               if (mem_be[b]) mem[mem_addr[10:3]][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= '0;
         end else begin
            mem_rdata <= mem[mem_addr[10:3]];
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [63:0] addr, input logic [63:0] val);
      pre_en  = 1'b1;
      pre_idx = addr[10:3];
      pre_val = val;
      @(negedge clk);
      pre_en  = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      exp_t e;
      int   en_cnt = 0;
      bit   got = 0;
      if (v.pre) preload(v.addr, v.pre_val);
      if (v.is_d) begin
         d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
      end else begin
         i_req = 1'b1; i_addr = v.addr;
      end
      sb.push_back('{v.is_d, v.exp_data, v.exp_err, v.exp_lat});
      for (int k = 1; k <= 8 && !got; k++) begin
         @(negedge clk);
         if (mem_we && !mem_en) chk("we_outside_issue", 64'(mem_we), 64'(0));
         if (mem_en) begin
            en_cnt++;
            chk("mem_addr", mem_addr, v.addr);
            chk("mem_we", 64'(mem_we), 64'(v.we));
            chk("mem_be", 64'(mem_be), 64'(v.we ? v.be : 8'hFF));
            if (v.we) chk("mem_wdata", mem_wdata, v.wdata);
         end
         if (i_ack || d_ack) begin
            got = 1;
            e = sb.pop_front();
            chk("ack_side", {62'b0, i_ack, d_ack}, e.is_d ? 64'd1 : 64'd2);
            chk("ack_latency", 64'(k), 64'(e.lat));
            chk("rdata", e.is_d ? d_rdata : {32'b0, i_rdata}, e.data);
            chk("i_err", 64'(i_err), 64'(e.err));
            i_req = 1'b0;
            d_req = 1'b0;
         end else begin
            chk("quiet_outputs", d_rdata | {31'b0, i_err, i_rdata}, 64'd0);
         end
      end
      if (!got) begin
         void'(sb.pop_front());
         chk("ack_timeout", 64'(got), 64'(1));
         i_req = 1'b0;
         d_req = 1'b0;
      end
      chk("mem_en_count", 64'(en_cnt), v.exp_err ? 64'd0 : 64'd1);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
      d_addr = '0; d_wdata = '0; d_be = '0; pre_en = 1'b0; pre_idx = '0; pre_val = '0;
      //          is_d we addr     wdata                   be     pre pre_val                 exp_data                err lat
      vecs[0]  = '{0, 0, 64'h104, 64'h0,                  8'h00, 1, 64'hAAAABBBBCCCCDDDD, 64'hAAAABBBB,          0, 2};
      vecs[1]  = '{0, 0, 64'h100, 64'h0,                  8'h00, 0, 64'h0,                64'hCCCCDDDD,          0, 2};
      vecs[2]  = '{0, 0, 64'h102, 64'h0,                  8'h00, 0, 64'h0,                64'h0,                 1, 1};
      vecs[3]  = '{0, 0, 64'h107, 64'h0,                  8'h00, 0, 64'h0,                64'h0,                 1, 1};
      vecs[4]  = '{1, 0, 64'h40,  64'h0,                  8'h00, 1, 64'hFFEEDDCCBBAA9988, 64'hFFEEDDCCBBAA9988, 0, 2};
      vecs[5]  = '{1, 1, 64'h40,  64'h1122334455667788,   8'h0F, 0, 64'h0,                64'h0,                 0, 2};
      vecs[6]  = '{1, 0, 64'h40,  64'h0,                  8'h00, 0, 64'h0,                64'hFFEEDDCC55667788, 0, 2};
      vecs[7]  = '{0, 0, 64'h40,  64'h0,                  8'h00, 0, 64'h0,                64'h55667788,          0, 2};
      vecs[8]  = '{0, 0, 64'h44,  64'h0,                  8'h00, 0, 64'h0,                64'hFFEEDDCC,          0, 2};
      vecs[9]  = '{1, 0, 64'h48,  64'h0,                  8'h00, 1, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 0, 2};
      vecs[10] = '{1, 1, 64'h48,  64'hDEADBEEFCAFEF00D,   8'hF0, 0, 64'h0,                64'h0,                 0, 2};
      vecs[11] = '{1, 0, 64'h48,  64'h0,                  8'h00, 0, 64'h0,                64'hDEADBEEF89ABCDEF, 0, 2};

      // both requesters held through reset: outputs stay quiet, then D, I, D, I back to back
      i_req = 1'b1; i_addr = 64'h100; d_req = 1'b1; d_addr = 64'h40;
      repeat (3) begin
         @(negedge clk);
         chk("rst_ctl", {59'b0, i_ack, i_err, d_ack, mem_en, mem_we}, 64'd0);
         chk("rst_data", d_rdata | mem_addr | mem_wdata | {24'b0, mem_be, i_rdata}, 64'd0);
      end
      reset = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         chk($sformatf("rr_en_%0d", k), 64'(mem_en), 64'(k % 2));
         chk($sformatf("rr_dack_%0d", k), 64'(d_ack), 64'(k == 2 || k == 6));
         chk($sformatf("rr_iack_%0d", k), 64'(i_ack), 64'(k == 4 || k == 8));
      end
      i_req = 1'b0;
      d_req = 1'b0;
      @(negedge clk);

      foreach (vecs[n]) run_vec(vecs[n]);

      // reset asserted while a store sits in ISSUE: no write, no ack, back to IDLE
      preload(64'h80, 64'h5555AAAA5555AAAA);
      d_req = 1'b1; d_we = 1'b1; d_addr = 64'h80; d_wdata = 64'h0102030405060708; d_be = 8'hFF;
      @(negedge clk);
      chk("abort_issue", {62'b0, mem_en, mem_we}, 64'd3);
      reset = 1'b0;
      #1;
      chk("abort_gated", {61'b0, mem_en, mem_we, d_ack}, 64'd0);
      @(negedge clk);
      chk("abort_rst_ack", 64'(d_ack), 64'd0);
      reset = 1'b1;
      d_req = 1'b0;
      @(negedge clk);
      chk("abort_idle", {62'b0, mem_en, d_ack}, 64'd0);
      chk("abort_mem", mem[8'h10], 64'h5555AAAA5555AAAA);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
